// File: rtl/xnor_popcount_accumulator.sv
// Binary-neuron stage: each input beat is XNORed with a stored weight chunk and popcounted.
// The counts are summed over CHUNKS beats, then the total and (total > threshold) are held.
module xnor_popcount_accumulator #(
    parameter int INPUTS   = 8,
    parameter int CHUNKS   = 4,
    parameter int ACC_BITS = $clog2(INPUTS * CHUNKS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                abort,
    input  logic                weight_load,
    input  logic [INPUTS-1:0]   weight_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INPUTS-1:0]   in_data,
    input  logic [ACC_BITS-1:0] threshold,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic [ACC_BITS-1:0] out_count
);
    localparam int BEAT_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PC_BITS   = $clog2(INPUTS + 1);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(CHUNKS - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic logic [PC_BITS-1:0] popcount(input logic [INPUTS-1:0] vec);
        logic [PC_BITS-1:0] cnt;
        cnt = {PC_BITS{1'b0}};
        for (int i = 0; i < INPUTS; i++) begin
            cnt = cnt + PC_BITS'(vec[i]);
        end
        return cnt;
    endfunction

    state_t                state_r, state_nxt_s;
    logic [BEAT_BITS-1:0]  beat_r, beat_nxt_s;
    logic [BEAT_BITS-1:0]  wptr_r;
    logic [ACC_BITS-1:0]   acc_r, acc_nxt_s;
    logic                  out_valid_r, out_valid_nxt_s;
    logic                  out_bit_r, out_bit_nxt_s;
    logic [ACC_BITS-1:0]   out_count_r, out_count_nxt_s;
    logic [INPUTS-1:0]     weight_r [CHUNKS];

    logic                  beat_fire_s;
    logic                  wload_fire_s;
    logic [PC_BITS-1:0]    pc_s;
    logic [ACC_BITS-1:0]   sum_s;

    assign in_ready     = (state_r == ST_ACCUM) && !weight_load && !abort;
    assign beat_fire_s  = in_valid && in_ready;
    // Weights may only change between evaluations, never under a partial sum.
    assign wload_fire_s = weight_load && !abort && (state_r == ST_ACCUM) &&
                          (beat_r == {BEAT_BITS{1'b0}});

    assign out_valid = out_valid_r;
    assign out_bit   = out_bit_r;
    assign out_count = out_count_r;

    // Per-beat match count and running total including this beat.
    always_comb begin
        pc_s = popcount(~(in_data ^ weight_r[beat_r]));
        if (beat_r == {BEAT_BITS{1'b0}}) begin
            sum_s = ACC_BITS'(pc_s);
        end else begin
            sum_s = acc_r + ACC_BITS'(pc_s);
        end
    end

    // Next-state and output-register logic; abort dominates everything.
    always_comb begin
        state_nxt_s     = state_r;
        beat_nxt_s      = beat_r;
        acc_nxt_s       = acc_r;
        out_valid_nxt_s = out_valid_r;
        out_bit_nxt_s   = out_bit_r;
        out_count_nxt_s = out_count_r;
        if (abort) begin
            state_nxt_s     = ST_ACCUM;
            beat_nxt_s      = {BEAT_BITS{1'b0}};
            acc_nxt_s       = {ACC_BITS{1'b0}};
            out_valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (beat_fire_s) begin
                        if (beat_r == LAST_BEAT) begin
                            state_nxt_s     = ST_HOLD;
                            beat_nxt_s      = {BEAT_BITS{1'b0}};
                            acc_nxt_s       = {ACC_BITS{1'b0}};
                            out_valid_nxt_s = 1'b1;
                            out_bit_nxt_s   = (sum_s > threshold);
                            out_count_nxt_s = sum_s;
                        end else begin
                            beat_nxt_s = beat_r + BEAT_BITS'(1);
                            acc_nxt_s  = sum_s;
                        end
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_nxt_s     = ST_ACCUM;
                        out_valid_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s     = ST_ACCUM;
                    beat_nxt_s      = {BEAT_BITS{1'b0}};
                    acc_nxt_s       = {ACC_BITS{1'b0}};
                    out_valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACCUM;
            beat_r      <= {BEAT_BITS{1'b0}};
            acc_r       <= {ACC_BITS{1'b0}};
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            out_count_r <= {ACC_BITS{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            beat_r      <= beat_nxt_s;
            acc_r       <= acc_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_bit_r   <= out_bit_nxt_s;
            out_count_r <= out_count_nxt_s;
        end
    end

    // Weight store with wrapping write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= {BEAT_BITS{1'b0}};
            for (int i = 0; i < CHUNKS; i++) begin
                weight_r[i] <= {INPUTS{1'b0}};
            end
        end else if (wload_fire_s) begin
            weight_r[wptr_r] <= weight_in;
            if (wptr_r == LAST_BEAT) begin
                wptr_r <= {BEAT_BITS{1'b0}};
            end else begin
                wptr_r <= wptr_r + BEAT_BITS'(1);
            end
        end else begin
            wptr_r <= wptr_r;
        end
    end

endmodule

// File: tb/tb_xnor_popcount_accumulator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model (queue of accepted beats, weight array, held result).
module tb_xnor_popcount_accumulator;
    localparam int INPUTS   = 8;
    localparam int CHUNKS   = 4;
    localparam int ACC_BITS = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                abort;
    logic                weight_load;
    logic [INPUTS-1:0]   weight_in;
    logic                in_valid;
    logic                in_ready;
    logic [INPUTS-1:0]   in_data;
    logic [ACC_BITS-1:0] threshold;
    logic                out_valid;
    logic                out_ready;
    logic                out_bit;
    logic [ACC_BITS-1:0] out_count;

    int checks = 0;
    int failures = 0;

    logic [INPUTS-1:0] m_w [CHUNKS];
    int                m_wptr;
    logic [INPUTS-1:0] m_beats [$];
    bit                m_valid;
    int                m_count;
    bit                m_bit;

    xnor_popcount_accumulator #(.INPUTS(INPUTS), .CHUNKS(CHUNKS), .ACC_BITS(ACC_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .weight_load(weight_load),
        .weight_in(weight_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .threshold(threshold), .out_valid(out_valid),
        .out_ready(out_ready), .out_bit(out_bit), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CHUNKS; i++) m_w[i] = '0;
        m_wptr = 0;
        m_beats.delete();
        m_valid = 1'b0;
        m_count = 0;
        m_bit = 1'b0;
    endtask

    // Applies one clock edge's worth of behaviour from the current inputs.
    task automatic model_edge();
        int total;
        if (abort) begin
            m_beats.delete();
            m_valid = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (weight_load) begin
            if (m_beats.size() == 0) begin
                m_w[m_wptr] = weight_in;
                m_wptr = (m_wptr + 1) % CHUNKS;
            end
        end else if (in_valid) begin
            m_beats.push_back(in_data);
            if (m_beats.size() == CHUNKS) begin
                total = 0;
                for (int i = 0; i < CHUNKS; i++) total += $countones(~(m_beats[i] ^ m_w[i]));
                m_count = total;
                m_bit = (total > int'(threshold));
                m_valid = 1'b1;
                m_beats.delete();
            end
        end
    endtask

    task automatic step(input string tag);
        logic exp_ready;
        exp_ready = !m_valid && !weight_load && !abort;
        #1;
        check_val({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        check_val({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check_val({tag, ".out_bit"}, 32'(out_bit), 32'(m_bit));
        check_val({tag, ".out_count"}, 32'(out_count), 32'(m_count));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic wl, input logic [7:0] wi,
                         input logic ab, input logic ordy, input logic [5:0] th, input string tag);
        in_valid = v; in_data = d; weight_load = wl; weight_in = wi;
        abort = ab; out_ready = ordy; threshold = th;
        step(tag);
    endtask

    task automatic feed4(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input logic [5:0] th);
        drive(1'b1, d0, 1'b0, 8'h00, 1'b0, 1'b0, th, "beat0");
        drive(1'b1, d1, 1'b0, 8'h00, 1'b0, 1'b0, th, "beat1");
        drive(1'b1, d2, 1'b0, 8'h00, 1'b0, 1'b0, th, "beat2");
        drive(1'b1, d3, 1'b0, 8'h00, 1'b0, 1'b0, th, "beat3");
    endtask

    task automatic load(input logic [7:0] wi);
        drive(1'b0, 8'h00, 1'b1, wi, 1'b0, 1'b0, 6'd0, "load");
    endtask

    task automatic release_out();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'd0, "release");
    endtask

    task automatic expect_result(input string tag, input int cnt, input logic b);
        check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_val({tag, ".count"}, 32'(out_count), 32'(cnt));
        check_val({tag, ".bit"}, 32'(out_bit), 32'(b));
    endtask

    // Mid-cycle asynchronous reset: outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        in_valid = 1'b0; weight_load = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val({tag, ".valid"}, 32'(out_valid), 32'd0);
        check_val({tag, ".bit"}, 32'(out_bit), 32'd0);
        check_val({tag, ".count"}, 32'(out_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=0 expected=1");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; weight_load = 1'b0; weight_in = '0;
        abort = 1'b0; out_ready = 1'b0; threshold = '0;
        model_reset();
        #12;
        check_val("reset.valid", 32'(out_valid), 32'd0);
        check_val("reset.count", 32'(out_count), 32'd0);
        check_val("reset.bit", 32'(out_bit), 32'd0);
        check_val("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero weights: all-zero beats match everywhere.
        feed4(8'h00, 8'h00, 8'h00, 8'h00, 6'd31);
        expect_result("tp1a", 32, 1'b1);
        release_out();
        feed4(8'h00, 8'h00, 8'h00, 8'h00, 6'd32);
        expect_result("tp1b", 32, 1'b0);
        release_out();

        load(8'hA5); load(8'hFF); load(8'h00); load(8'h0F);
        feed4(8'hA5, 8'hFF, 8'h00, 8'h0F, 6'd0);
        expect_result("tp2a", 32, 1'b1);
        release_out();
        feed4(8'h5A, 8'h00, 8'hFF, 8'hF0, 6'd0);
        expect_result("tp2b", 0, 1'b0);
        release_out();
        feed4(8'hA4, 8'hFF, 8'h00, 8'h0F, 6'd0);
        expect_result("tp2c", 31, 1'b1);

        // Backpressure while upstream keeps offering a beat.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, "bp");
        expect_result("tp3.hold", 31, 1'b1);
        drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 6'd0, "bp_release");
        check_val("tp3.dropped", 32'(out_valid), 32'd0);
        feed4(8'hA5, 8'hFF, 8'h00, 8'h0F, 6'd40);
        expect_result("tp3.next", 32, 1'b0);
        release_out();

        // Mid-evaluation weight_load is ignored.
        drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 6'd10, "wp0");
        drive(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 6'd10, "wp1");
        drive(1'b1, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0, 6'd10, "wp_pulse");
        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 6'd10, "wp2");
        drive(1'b1, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 6'd10, "wp3");
        expect_result("tp4a", 32, 1'b1);
        release_out();
        feed4(8'hA5, 8'hFF, 8'h00, 8'h0F, 6'd0);
        expect_result("tp4a.weights", 32, 1'b1);
        release_out();

        async_reset("rst_idle");
        load(8'h11); load(8'h22); load(8'h33); load(8'h44); load(8'h55);
        feed4(8'h55, 8'h22, 8'h33, 8'h44, 6'd31);
        expect_result("tp4b", 32, 1'b1);
        release_out();

        // Abort discards partial work; abort cycle takes neither beat nor weight.
        async_reset("rst_pre_abort");
        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, "ab0");
        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, "ab1");
        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, "ab2");
        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, "abort");
        check_val("tp5.no_valid", 32'(out_valid), 32'd0);
        feed4(8'h00, 8'h00, 8'h00, 8'h00, 6'd0);
        expect_result("tp5a", 32, 1'b1);
        release_out();
        drive(1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 6'd0, "abort_all");
        feed4(8'h00, 8'h00, 8'h00, 8'h00, 6'd0);
        expect_result("tp5b", 32, 1'b1);
        release_out();

        // Asynchronous reset mid-evaluation and in HOLD clears weights too.
        load(8'hFF); load(8'hFF); load(8'hFF); load(8'hFF);
        feed4(8'hFF, 8'hFF, 8'hFF, 8'hFF, 6'd0);
        expect_result("tp6.pre", 32, 1'b1);
        release_out();
        drive(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, "r0");
        drive(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, "r1");
        async_reset("tp6.mid");
        feed4(8'hFF, 8'hFF, 8'hFF, 8'hFF, 6'd0);
        expect_result("tp6.zero_w", 0, 1'b0);
        release_out();
        feed4(8'h00, 8'h0F, 8'h00, 8'h00, 6'd5);
        expect_result("tp6.hold_pre", 28, 1'b1);
        async_reset("tp6.hold");

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
                  8'($urandom), $urandom_range(0, 29) == 0, 1'($urandom),
                  6'($urandom_range(0, 40)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
